// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: iterative BCD/hex digit converter feeding a multiplexed 4-digit common-anode display
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 100_000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        decimal_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        conv_busy,
    output logic        update_tick
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [4:0] DASH = 5'd16, BLANK = 5'd17;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [15:0] bin_q, bin_d, val_q, val_d;
    logic [19:0] bcd_q, bcd_d, adj;
    logic [3:0] dpi_q, dpi_d, dpr_q, dpr_d, new_dp;
    logic dec_q, dec_d, lz, wrap;
    logic [3:0][4:0] dig_q, dig_d, new_dig;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic dp_q, dp_d;
    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:  glyph = 7'b1000000;
            5'd1:  glyph = 7'b1111001;
            5'd2:  glyph = 7'b0100100;
            5'd3:  glyph = 7'b0110000;
            5'd4:  glyph = 7'b0011001;
            5'd5:  glyph = 7'b0010010;
            5'd6:  glyph = 7'b0000010;
            5'd7:  glyph = 7'b1111000;
            5'd8:  glyph = 7'b0000000;
            5'd9:  glyph = 7'b0010000;
            5'd10: glyph = 7'b0001000;
            5'd11: glyph = 7'b0000011;
            5'd12: glyph = 7'b1000110;
            5'd13: glyph = 7'b0100001;
            5'd14: glyph = 7'b0000110;
            5'd15: glyph = 7'b0001110;
            5'd16: glyph = 7'b0111111;
            default: glyph = 7'b1111111;
        endcase
    endfunction
    // Digit codes: 0-15 nibble glyphs, DASH for overflow, BLANK for suppressed leading zeros
    always_comb begin
        for (int i = 0; i < 5; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        lz = 1'b1;
        new_dp = (dec_q && bcd_q[19:16] != 4'd0) ? 4'b0000 : dpi_q;
        for (int k = 3; k >= 0; k--) begin
            lz = lz && bcd_q[4*k +: 4] == 4'd0 && !dpi_q[k];
            new_dig[k] = !dec_q ? {1'b0, val_q[4*k +: 4]} :
                         bcd_q[19:16] != 4'd0 ? DASH :
                         (LZ_BLANK && lz && k != 0) ? BLANK : {1'b0, bcd_q[4*k +: 4]};
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        val_d = val_q;
        dpi_d = dpi_q;
        dec_d = dec_q;
        dig_d = dig_q;
        dpr_d = dpr_q;
        case (state_q)
            IDLE: begin
                bin_d = value_in;
                val_d = value_in;
                dpi_d = dp_in;
                dec_d = decimal_en;
                bcd_d = '0;
                cnt_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                state_d = cnt_q == 4'd15 ? COMMIT : SHIFT;
            end
            default: begin
                dig_d = new_dig;
                dpr_d = new_dp;
                state_d = IDLE;
            end
        endcase
        wrap = ref_q == RW'(REFRESH_DIV - 1);
        ref_d = wrap ? '0 : ref_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        an_d = ~(4'b0001 << idx_q);
        seg_d = glyph(dig_q[idx_q]);
        dp_d = ~dpr_q[idx_q];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bin_q <= '0;
            bcd_q <= '0;
            val_q <= '0;
            dpi_q <= '0;
            dec_q <= 1'b0;
            dig_q <= {4{BLANK}};
            dpr_q <= '0;
            ref_q <= '0;
            idx_q <= '0;
            an_q <= 4'hF;
            seg_q <= 7'h7F;
            dp_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            val_q <= val_d;
            dpi_q <= dpi_d;
            dec_q <= dec_d;
            dig_q <= dig_d;
            dpr_q <= dpr_d;
            ref_q <= ref_d;
            idx_q <= idx_d;
            an_q <= an_d;
            seg_q <= seg_d;
            dp_q <= dp_d;
        end
    end
    assign an = an_q;
    assign seg = seg_q;
    assign dp = dp_q;
    assign conv_busy = state_q != IDLE;
    assign update_tick = state_q == COMMIT;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: randomized self-checking bench against an arithmetic display model
module tb_seven_seg_scan_driver;
    logic clk = 1'b0, reset = 1'b1, decimal_en = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0] dp_in = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp, conv_busy, update_tick;
    int checks = 0, errors = 0, bad_an = 0;
    logic [6:0] cap_seg [4];
    logic cap_dp [4];
    localparam logic [6:0] GLYPH [18] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
        7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b0111111, 7'b1111111};

    seven_seg_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .dp_in(dp_in),
        .decimal_en(decimal_en), .an(an), .seg(seg), .dp(dp),
        .conv_busy(conv_busy), .update_tick(update_tick));

    always #5 clk = ~clk;

    // Returns {dp_on[3:0], seg3, seg2, seg1, seg0} for what each digit should show
    function automatic logic [31:0] model(input int v, input logic [3:0] dpv, input bit dec);
        logic [31:0] r;
        int p, g;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (!dec) g = (v >> (4 * k)) & 15;
            else if (v > 9999) g = 16;
            else if (k > 0 && v < p && (dpv >> k) == 0) g = 17;
            else g = (v / p) % 10;
            r[7*k +: 7] = GLYPH[g];
            r[28+k] = (dec && v > 9999) ? 1'b0 : dpv[k];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!update_tick && n < 40);
        if (!update_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: update_tick=%b after %0d cycles, required 1 within 40", update_tick, n);
        end
    endtask

    task automatic capture();
        bad_an = 0;
        for (int k = 0; k < 4; k++) begin
            cap_seg[k] = 'x;
            cap_dp[k] = 1'bx;
        end
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin cap_seg[0] = seg; cap_dp[0] = dp; end
                4'b1101: begin cap_seg[1] = seg; cap_dp[1] = dp; end
                4'b1011: begin cap_seg[2] = seg; cap_dp[2] = dp; end
                4'b0111: begin cap_seg[3] = seg; cap_dp[3] = dp; end
                default: bad_an++;
            endcase
        end
    endtask

    task automatic apply(input int v, input logic [3:0] dpv, input bit dec);
        wait_tick();
        value_in = 16'(v);
        dp_in = dpv;
        decimal_en = dec;
        wait_tick();
        capture();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        value_in = '0;
        dp_in = '0;
        decimal_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || conv_busy !== 1'b0 || update_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: an=%b seg=%b dp=%b busy=%b tick=%b required 1111 1111111 1 0 0",
                     an, seg, dp, conv_busy, update_tick);
        end
        reset = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            logic [3:0] exp_an;
            if (n > 1) @(negedge clk);
            exp_an = n == 1 ? 4'hF : ~(4'b0001 << (((n - 2) / 4) % 4));
            checks++;
            if (an !== exp_an) begin
                errors++;
                $display("FAIL reset_an cycle%0d: an=%b required %b", n, an, exp_an);
            end
            checks++;
            if (seg !== 7'h7F || dp !== 1'b1) begin
                errors++;
                $display("FAIL reset_blank cycle%0d: seg=%b dp=%b required 1111111 1", n, seg, dp);
            end
            checks++;
            if (update_tick !== (n == 18) || conv_busy !== (n >= 2 && n <= 18)) begin
                errors++;
                $display("FAIL reset_fsm cycle%0d: tick=%b busy=%b required %b %b",
                         n, update_tick, conv_busy, n == 18, n >= 2 && n <= 18);
            end
        end
    endtask

    task automatic test_decimal();
        int vals [7] = '{3300, 42, 5, 0, 9999, 1000, 70};
        logic [3:0] dps [7] = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            logic [31:0] exp;
            apply(vals[i], dps[i], 1'b1);
            exp = model(vals[i], dps[i], 1'b1);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[k] !== exp[7*k +: 7] || cap_dp[k] !== ~exp[28+k]) begin
                    errors++;
                    $display("FAIL decimal v=%0d digit%0d: seg=%b dp=%b required %b %b",
                             vals[i], k, cap_seg[k], cap_dp[k], exp[7*k +: 7], ~exp[28+k]);
                end
            end
            checks++;
            if (bad_an !== 0) begin
                errors++;
                $display("FAIL decimal_an v=%0d: bad anode cycles=%0d required 0", vals[i], bad_an);
            end
        end
    endtask

    task automatic test_hex();
        int vals [3] = '{16'hA5F0, 16'h0000, 16'h1B2C};
        logic [3:0] dps [3] = '{4'b0000, 4'b0101, 4'b1010};
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp;
            apply(vals[i], dps[i], 1'b0);
            exp = model(vals[i], dps[i], 1'b0);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[k] !== exp[7*k +: 7] || cap_dp[k] !== ~exp[28+k]) begin
                    errors++;
                    $display("FAIL hex v=%h digit%0d: seg=%b dp=%b required %b %b",
                             vals[i], k, cap_seg[k], cap_dp[k], exp[7*k +: 7], ~exp[28+k]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int vals [3] = '{12345, 10000, 65535};
        for (int i = 0; i < 3; i++) begin
            apply(vals[i], 4'b1000, 1'b1);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[k] !== 7'b0111111 || cap_dp[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL overflow v=%0d digit%0d: seg=%b dp=%b required 0111111 1",
                             vals[i], k, cap_seg[k], cap_dp[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            bit dec;
            int v;
            logic [3:0] dpv;
            logic [31:0] exp;
            dec = 1'($urandom_range(0, 1));
            v = dec ? int'($urandom_range(0, 12000)) : int'($urandom_range(0, 65535));
            dpv = 4'($urandom_range(0, 15));
            apply(v, dpv, dec);
            exp = model(v, dpv, dec);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_seg[k] !== exp[7*k +: 7] || cap_dp[k] !== ~exp[28+k]) begin
                    errors++;
                    $display("FAIL random v=%0d dec=%0d dp_in=%b digit%0d: seg=%b dp=%b required %b %b",
                             v, dec, dpv, k, cap_seg[k], cap_dp[k], exp[7*k +: 7], ~exp[28+k]);
                end
            end
        end
    endtask

    task automatic test_midchange();
        logic [31:0] exp_a, exp_b;
        exp_a = model(1234, 4'b0000, 1'b1);
        exp_b = model(867, 4'b0000, 1'b1);
        wait_tick();
        value_in = 16'd1234;
        dp_in = '0;
        decimal_en = 1'b1;
        repeat (6) @(negedge clk);
        value_in = 16'd867;
        wait_tick();
        capture();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_seg[k] !== exp_a[7*k +: 7]) begin
                errors++;
                $display("FAIL midchange_old digit%0d: seg=%b required %b", k, cap_seg[k], exp_a[7*k +: 7]);
            end
        end
        wait_tick();
        capture();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_seg[k] !== exp_b[7*k +: 7]) begin
                errors++;
                $display("FAIL midchange_new digit%0d: seg=%b required %b", k, cap_seg[k], exp_b[7*k +: 7]);
            end
        end
    endtask

    task automatic test_reset_abort();
        wait_tick();
        value_in = 16'h1234;
        decimal_en = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            if (n > 1) @(negedge clk);
            checks++;
            if (update_tick !== 1'b0 || seg !== 7'h7F || dp !== 1'b1) begin
                errors++;
                $display("FAIL abort cycle%0d: tick=%b seg=%b dp=%b required 0 1111111 1", n, update_tick, seg, dp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_hex();
        test_overflow();
        test_random();
        test_midchange();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
